// File: rtl/namco_ctrl_latch.sv
// Addressable control-latch bank shared by the main and sub 6809 buses.
// Drives IRQ enables and requests, the sub-CPU and I/O resets, sound enable and BG scroll.
module namco_ctrl_latch #(
    parameter int          NLATCH     = 8,
    parameter logic [15:0] MBASE      = 16'h5000,
    parameter logic [15:0] SBASE      = 16'h2000,
    parameter bit          SCPU_WR_EN = 1'b1,
    parameter bit          IRQ_MODE   = 1'b0,
    parameter int          RST_HOLD   = 16,
    parameter bit          SCROLL_EN  = 1'b1,
    parameter logic [4:0]  SCRBASE    = 5'b00111
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              vblank_i,
    input  logic [15:0]       mcpu_adrs_i,
    input  logic              mcpu_vma_i,
    input  logic              mcpu_we_i,
    input  logic [15:0]       scpu_adrs_i,
    input  logic              scpu_vma_i,
    input  logic              scpu_we_i,
    output logic [NLATCH-1:0] latch_o,
    output logic              mcpu_irq_o,
    output logic              scpu_irq_o,
    output logic              scpu_reset_o,
    output logic              io_reset_o,
    output logic              psg_enable_o,
    output logic [7:0]        scroll_o
);

    localparam int         LB   = $clog2(NLATCH);
    localparam logic [7:0] HOLD = RST_HOLD[7:0];

    logic [NLATCH-1:0] latch_q, latch_d;
    logic [1:0]        pend_q, pend_d;
    logic              vb_m1_q, vb_s_q, vb_d_q;
    logic [7:0]        cnt_q, cnt_d;
    logic              srst_q, srst_d;
    logic [7:0]        scroll_q, scroll_d;

    logic          m_hit, s_hit, s_ok, scr_hit, vb_rise;
    logic [LB-1:0] m_idx, s_idx;
    logic          m_dat, s_dat;
    logic [1:0]    ack;

    assign m_idx = mcpu_adrs_i[LB:1];
    assign m_dat = mcpu_adrs_i[0];
    assign s_idx = scpu_adrs_i[LB:1];
    assign s_dat = scpu_adrs_i[0];

    assign m_hit = mcpu_vma_i & mcpu_we_i & (mcpu_adrs_i[15:LB+1] == MBASE[15:LB+1]);

    // The sub CPU only reaches its own IRQ enable, the generic bit 2, PSG and its run bit.
    assign s_ok  = (s_idx == LB'(0)) || (s_idx == LB'(2)) ||
                   (s_idx == LB'(3)) || (s_idx == LB'(5));
    assign s_hit = SCPU_WR_EN & scpu_vma_i & scpu_we_i & s_ok &
                   (scpu_adrs_i[15:LB+1] == SBASE[15:LB+1]);

    assign scr_hit = SCROLL_EN & mcpu_vma_i & mcpu_we_i & (mcpu_adrs_i[15:11] == SCRBASE);
    assign vb_rise = vb_s_q & ~vb_d_q;

    always_comb begin
        latch_d = latch_q;
        if (m_hit) latch_d[m_idx] = m_dat;
        if (s_hit) latch_d[s_idx] = s_dat;
    end

    // A write that leaves an enable at 0 acknowledges that channel's pending flag.
    assign ack[0] = ((m_hit && (m_idx == LB'(0))) || (s_hit && (s_idx == LB'(0)))) && !latch_d[0];
    assign ack[1] = ((m_hit && (m_idx == LB'(1))) || (s_hit && (s_idx == LB'(1)))) && !latch_d[1];

    always_comb begin
        pend_d = pend_q;
        for (int b = 0; b < 2; b++) begin
            if (vb_rise && latch_q[b]) pend_d[b] = 1'b1;
            if (ack[b])                pend_d[b] = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!latch_q[5])
            cnt_d = HOLD;
        else if (cnt_q != 8'd0)
            cnt_d = cnt_q - 8'd1;
        srst_d = ~latch_d[5] | (cnt_d != 8'd0);
    end

    always_comb begin
        scroll_d = scroll_q;
        if (scr_hit) scroll_d = mcpu_adrs_i[10:3];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            latch_q  <= '0;
            pend_q   <= '0;
            vb_m1_q  <= 1'b0;
            vb_s_q   <= 1'b0;
            vb_d_q   <= 1'b0;
            cnt_q    <= HOLD;
            srst_q   <= 1'b1;
            scroll_q <= '0;
        end else begin
            latch_q  <= latch_d;
            pend_q   <= pend_d;
            vb_m1_q  <= vblank_i;
            vb_s_q   <= vb_m1_q;
            vb_d_q   <= vb_s_q;
            cnt_q    <= cnt_d;
            srst_q   <= srst_d;
            scroll_q <= scroll_d;
        end
    end

    assign latch_o      = latch_q;
    assign mcpu_irq_o   = IRQ_MODE ? pend_q[1] : (latch_q[1] & vb_s_q);
    assign scpu_irq_o   = IRQ_MODE ? pend_q[0] : (latch_q[0] & vb_s_q);
    assign scpu_reset_o = srst_q;
    assign io_reset_o   = ~latch_q[4];
    assign psg_enable_o = latch_q[3];
    assign scroll_o     = scroll_q;

endmodule

// File: tb/tb_namco_ctrl_latch.sv
// Bench for namco_ctrl_latch: a level-IRQ and an edge-IRQ instance driven by the same buses,
// each checked every cycle against a behavioural model through an expectation queue.
module tb_namco_ctrl_latch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vb = 1'b0;
    logic        mv = 1'b0, mw = 1'b0, sv = 1'b0, sw = 1'b0;
    logic [15:0] ma = '0, sa = '0;

    logic [7:0] a_latch, b_latch, a_scroll, b_scroll;
    logic a_mirq, a_sirq, a_srst, a_io, a_psg;
    logic b_mirq, b_sirq, b_srst, b_io, b_psg;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    namco_ctrl_latch #(.IRQ_MODE(1'b0), .SCROLL_EN(1'b1), .RST_HOLD(16)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .vblank_i(vb),
        .mcpu_adrs_i(ma), .mcpu_vma_i(mv), .mcpu_we_i(mw),
        .scpu_adrs_i(sa), .scpu_vma_i(sv), .scpu_we_i(sw),
        .latch_o(a_latch), .mcpu_irq_o(a_mirq), .scpu_irq_o(a_sirq),
        .scpu_reset_o(a_srst), .io_reset_o(a_io), .psg_enable_o(a_psg), .scroll_o(a_scroll));

    namco_ctrl_latch #(.IRQ_MODE(1'b1), .SCROLL_EN(1'b0), .RST_HOLD(5)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .vblank_i(vb),
        .mcpu_adrs_i(ma), .mcpu_vma_i(mv), .mcpu_we_i(mw),
        .scpu_adrs_i(sa), .scpu_vma_i(sv), .scpu_we_i(sw),
        .latch_o(b_latch), .mcpu_irq_o(b_mirq), .scpu_irq_o(b_sirq),
        .scpu_reset_o(b_srst), .io_reset_o(b_io), .psg_enable_o(b_psg), .scroll_o(b_scroll));

    // Model state: h0/h1/h2 are VBLANK as sampled 0/1/2 edges ago; run counts edges since bit 5 went high.
    typedef struct packed {
        logic [7:0]  latch;
        logic        pm;
        logic        ps;
        logic        h0;
        logic        h1;
        logic        h2;
        logic [15:0] run;
        logic [7:0]  scroll;
    } mst_t;

    typedef struct packed {
        logic [7:0] latch;
        logic       mirq;
        logic       sirq;
        logic       srst;
        logic       io;
        logic       psg;
        logic [7:0] scroll;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    exp_t expq[$];
    mst_t mod_a = '0;
    mst_t mod_b = '0;

    function automatic mst_t m_step(mst_t s, bit irqm, bit scren);
        mst_t n;
        bit [7:0] wr;
        int mi, si;
        bit mhit, shit, rise;
        if (!rst_n) return '0;
        n  = s;
        wr = '0;
        mi = int'(ma[3:1]);
        si = int'(sa[3:1]);
        mhit = mv && mw && (ma[15:4] == 12'h500);
        shit = sv && sw && (sa[15:4] == 12'h200) && (si inside {0, 2, 3, 5});
        if (mhit) begin n.latch[mi] = ma[0]; wr[mi] = 1'b1; end
        if (shit) begin n.latch[si] = sa[0]; wr[si] = 1'b1; end
        rise = s.h1 && !s.h2;
        if (irqm) begin
            if (rise && s.latch[1]) n.pm = 1'b1;
            if (wr[1] && !n.latch[1]) n.pm = 1'b0;
            if (rise && s.latch[0]) n.ps = 1'b1;
            if (wr[0] && !n.latch[0]) n.ps = 1'b0;
        end
        if (n.latch[5] && s.latch[5])
            n.run = (s.run < 16'd1000) ? s.run + 16'd1 : s.run;
        else
            n.run = '0;
        if (scren && mv && mw && (ma[15:11] == 5'b00111)) n.scroll = ma[10:3];
        n.h2 = s.h1;
        n.h1 = s.h0;
        n.h0 = vb;
        return n;
    endfunction

    function automatic obs_t m_obs(mst_t s, bit irqm, int hold);
        obs_t o;
        o.latch  = s.latch;
        o.mirq   = irqm ? s.pm : (s.latch[1] & s.h1);
        o.sirq   = irqm ? s.ps : (s.latch[0] & s.h1);
        o.srst   = !s.latch[5] || (int'(s.run) < hold);
        o.io     = !s.latch[4];
        o.psg    = s.latch[3];
        o.scroll = s.scroll;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_obs(input string tag, input obs_t act, input obs_t exp);
        chk({tag, ".latch"},  16'(act.latch),  16'(exp.latch));
        chk({tag, ".mirq"},   16'(act.mirq),   16'(exp.mirq));
        chk({tag, ".sirq"},   16'(act.sirq),   16'(exp.sirq));
        chk({tag, ".srst"},   16'(act.srst),   16'(exp.srst));
        chk({tag, ".io"},     16'(act.io),     16'(exp.io));
        chk({tag, ".psg"},    16'(act.psg),    16'(exp.psg));
        chk({tag, ".scroll"}, 16'(act.scroll), 16'(exp.scroll));
    endtask

    // Predict the effect of the upcoming edge, queue it, then let the edge happen.
    task automatic tick();
        exp_t e;
        mod_a = m_step(mod_a, 1'b0, 1'b1);
        mod_b = m_step(mod_b, 1'b1, 1'b0);
        e.a = m_obs(mod_a, 1'b0, 16);
        e.b = m_obs(mod_b, 1'b1, 5);
        expq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input logic m_v, input logic m_w, input logic [15:0] m_a,
                       input logic s_v, input logic s_w, input logic [15:0] s_a);
        mv = m_v; mw = m_w; ma = m_a;
        sv = s_v; sw = s_w; sa = s_a;
    endtask

    task automatic mwr(input logic [15:0] a);
        drv(1'b1, 1'b1, a, 1'b0, 1'b0, 16'h0000);
        tick();
        drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin : monitor
        exp_t e;
        obs_t act;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                act = '{a_latch, a_mirq, a_sirq, a_srst, a_io, a_psg, a_scroll};
                cmp_obs("A", act, e.a);
                act = '{b_latch, b_mirq, b_sirq, b_srst, b_io, b_psg, b_scroll};
                cmp_obs("B", act, e.b);
            end
        end
    end

    initial begin : stim
        int k;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_srst", 16'(a_srst), 16'd1);
        chk("rst_io", 16'(a_io), 16'd1);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("rel_latch", 16'(a_latch), 16'h0000);

        mwr(16'h5007);
        chk("psg_on", 16'(a_psg), 16'd1);
        mwr(16'h5009);
        chk("io_run", 16'(a_io), 16'd0);

        mwr(16'h500B);
        k = 0;
        while (a_srst && k < 40) begin
            tick();
            k++;
        end
        chk("hold_len", 16'(k), 16'd16);
        chk("b_run", 16'(b_srst), 16'd0);
        mwr(16'h500A);
        chk("b_reassert", 16'(b_srst), 16'd1);
        mwr(16'h500B);
        repeat (8) tick();
        mwr(16'h500A);
        chk("a_reassert", 16'(a_srst), 16'd1);
        mwr(16'h500B);
        repeat (15) tick();
        chk("reload_hold", 16'(a_srst), 16'd1);
        tick();
        chk("reload_fall", 16'(a_srst), 16'd0);

        drv(1'b1, 1'b1, 16'h5001, 1'b1, 1'b1, 16'h2000);
        tick();
        drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("collide", 16'(a_latch[0]), 16'd0);
        drv(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2009);
        tick();
        chk("sub_b4_ign", 16'(a_io), 16'd0);
        drv(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2005);
        tick();
        drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("sub_b2", 16'(a_latch[2]), 16'd1);

        mwr(16'h5003);
        vb = 1'b1;
        tick();
        chk("lvl_lat1", 16'(a_mirq), 16'd0);
        tick();
        chk("lvl_lat2", 16'(a_mirq), 16'd1);
        chk("edge_lat2", 16'(b_mirq), 16'd0);
        tick();
        chk("edge_lat3", 16'(b_mirq), 16'd1);
        vb = 1'b0;
        repeat (4) tick();
        chk("edge_held", 16'(b_mirq), 16'd1);
        chk("lvl_drop", 16'(a_mirq), 16'd0);
        mwr(16'h5002);
        chk("edge_ack", 16'(b_mirq), 16'd0);
        vb = 1'b1;
        repeat (4) tick();
        chk("edge_noen", 16'(b_mirq), 16'd0);
        vb = 1'b0;
        mwr(16'h5003);
        repeat (2) tick();
        chk("edge_noretro", 16'(b_mirq), 16'd0);

        mwr(16'h5001);
        vb = 1'b1;
        tick();
        chk("sirq_lat1", 16'(a_sirq), 16'd0);
        tick();
        chk("sirq_lat2", 16'(a_sirq), 16'd1);
        vb = 1'b0;
        tick();
        chk("sirq_fall1", 16'(a_sirq), 16'd1);
        tick();
        chk("sirq_fall2", 16'(a_sirq), 16'd0);

        mwr(16'h3A28);
        chk("scroll_a", 16'(a_scroll), 16'h0045);
        chk("scroll_b", 16'(b_scroll), 16'h0000);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) vb = ~vb;
            rst_n = ($urandom_range(0, 299) != 0);
            mv = ($urandom_range(0, 3) != 0);
            mw = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: ma = 16'h5000 | 16'($urandom_range(0, 15));
                1: ma = 16'h3800 | 16'($urandom_range(0, 2047));
                2: ma = 16'($urandom);
                default: ma = 16'h5010 | 16'($urandom_range(0, 15));
            endcase
            sv = ($urandom_range(0, 3) != 0);
            sw = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: sa = 16'h2000 | 16'($urandom_range(0, 5) << 1) | 16'($urandom_range(0, 1));
                1: sa = 16'($urandom);
                default: sa = 16'h2010 | 16'($urandom_range(0, 15));
            endcase
            tick();
        end
        rst_n = 1'b1;
        drv(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
